imem_responder: RTL and testbench
=================================

# imem_responder

Responder side of the instruction-fetch interface. The block accepts word fetch requests from the fetch unit and returns instruction words after a fixed, parameterised pipeline latency. It buffers responses so the fetch side can stall without losing data. It also provides a loader write port so testbenches and the boot path can fill the program image.

## Interface
Parameters:
- DEPTH_WORDS, 256: instruction words stored; power of 2, 16..4096. ADDR_W = log2(DEPTH_WORDS).
- LATENCY, 2: cycles from request acceptance to response availability; 1..4.
- FIFO_DEPTH, 4: response buffer entries, and the maximum number of outstanding requests; power of 2, at least 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address (the PC).
- resp_valid  out  1  response word available.
- resp_ready  in  1  fetch side consumes the response.
- resp_data  out  32  instruction word.
- resp_err  out  1  address fault for this response; present only with IMEM_ERR_EN.
- ld_we  in  1  loader write strobe.
- ld_addr  in  ADDR_W  loader word index.
- ld_data  in  32  loader write data.
- busy  out  1  at least one request outstanding or buffered.

## Operation
- Accept: a request is accepted on an edge where req_valid && req_ready. Word index = req_addr[ADDR_W+1:2].
- Array read: the array is read on the accept edge, and the word is captured into pipeline stage 1. Stages 2..LATENCY are a valid/data shift register.
- Buffering: the last stage pushes into the response FIFO. resp_valid = FIFO not empty; resp_data = FIFO head. The head is popped on an edge where resp_valid && resp_ready.
- Credit accounting: count = requests in the pipeline + FIFO entries.
  - req_ready = (count < FIFO_DEPTH), decoded from registered state only. There is no combinational path from resp_ready or req_valid to req_ready.
  - count increments on accept and decrements on pop; both on the same edge leave it unchanged.
  - The FIFO can therefore never overflow, and a push onto a full FIFO cannot occur.
- Ordering: responses return strictly in request order.
- Loader: ld_we writes ld_data to word ld_addr on the edge. The loader is independent of the fetch path and may be used at any time.
  - Loader write and fetch read of the same word on the same edge: the fetch returns the old word.
  - The new word is visible to requests accepted on later edges.
- busy = (count != 0).
- Array contents are not reset.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_data=0, resp_err=0, busy=0. Pipeline valids are cleared, the FIFO is emptied and count=0.
- Reset asserted mid-operation discards all in-flight and buffered responses. The loader write on a reset edge is dropped.
- Latency: for a request accepted on edge E0 with the FIFO empty, resp_valid is high after edge E_LATENCY. The response is never earlier than that.
- Throughput: one request per cycle is sustained when FIFO_DEPTH >= LATENCY+1 and resp_ready is held high.
- Backpressure: with resp_ready low, req_ready falls after FIFO_DEPTH accepts. resp_data and resp_err stay stable while resp_valid && !resp_ready.
- Simultaneous push and pop on a non-empty FIFO: the head advances and the new entry is appended, with no bubble.
- Simultaneous push and pop on an empty FIFO: not possible, because the pop requires resp_valid.

## Configuration
- IMEM_ERR_EN defined:
  - A request is faulted if req_addr[1:0] != 0, or if req_addr[31:ADDR_W+2] != 0 (out of range).
  - A faulted request still consumes a credit and its latency slot.
  - Its response has resp_err=1 and resp_data=32'h00000013 (NOP). The array is not read.
- IMEM_ERR_EN undefined:
  - The resp_err port is absent.
  - req_addr[1:0] and the upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.

## Test plan
- Reset behaviour: load word 0 = 32'h00500093 via the loader, then reset; request addr 0 -> resp_valid after exactly LATENCY edges with resp_data=32'h00500093, and busy=0 once the response is consumed.
- Streaming: load words 0..7 = 32'h1000+i; stream addresses 0,4,...,28 back-to-back with resp_ready=1 -> one response per cycle, in order, data 32'h1000..32'h1007, req_ready never low.
- Backpressure: hold resp_ready=0 and drive req_valid=1 -> exactly FIFO_DEPTH accepts, then req_ready=0 with resp_data held stable; release resp_ready -> all FIFO_DEPTH words delivered in order and none lost.
- Same-word collision: loader writes word 3 = 32'hDEADBEEF on the same edge a request for addr 12 is accepted -> that response carries the old word; the next request for addr 12 returns 32'hDEADBEEF.
- Reset mid-operation: assert reset with 3 requests outstanding -> resp_valid=0, req_ready=1, busy=0 immediately; none of the 3 responses appear after reset is released.
- Address faults, IMEM_ERR_EN defined: addr 32'h2 -> resp_err=1, data 32'h00000013; addr DEPTH_WORDS*4 -> resp_err=1. IMEM_ERR_EN undefined: addr DEPTH_WORDS*4 returns word 0.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-fetch responder: fixed-latency array read pipeline feeding a credit-guarded response FIFO.
// Optional IMEM_ERR_EN adds address-fault detection and the resp_err output.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_addr,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [31:0]                    resp_data,
`ifdef IMEM_ERR_EN
    output logic                           resp_err,
`endif
    input  logic                           ld_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [31:0]                    ld_data,
    output logic                           busy
);

    localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
`ifdef IMEM_ERR_EN
    localparam int unsigned ENTRY_W = 33;
    localparam logic [31:0] NOP     = 32'h0000_0013;
`else
    localparam int unsigned ENTRY_W = 32;
`endif

    logic [31:0]        mem [DEPTH_WORDS];
    logic [ADDR_W-1:0]  word_idx;
    logic [ENTRY_W-1:0] stage_in;
    logic               accept;
    logic               pop;
    logic               push;

    logic [LATENCY-1:0] pipe_valid_q;
    logic [ENTRY_W-1:0] pipe_data_q [LATENCY];

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENTRY_W-1:0] head;

    assign word_idx = req_addr[ADDR_W+1:2];

`ifdef IMEM_ERR_EN
    logic fault;
    assign fault    = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);
    assign stage_in = fault ? {1'b1, NOP} : {1'b0, mem[word_idx]};
`else
    // Byte offset and out-of-range bits are ignored so fetches wrap around the array.
    logic unused_addr;
    assign unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
    assign stage_in    = mem[word_idx];
`endif

    // Credits cover pipeline plus FIFO, so req_ready depends on registered state only.
    assign req_ready  = (count_q < CNT_W'(FIFO_DEPTH));
    assign accept     = req_valid && req_ready;
    assign resp_valid = (wr_ptr_q != rd_ptr_q);
    assign pop        = resp_valid && resp_ready;
    assign push       = pipe_valid_q[LATENCY-1];
    assign busy       = (count_q != '0);
    assign head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign resp_data  = resp_valid ? head[31:0] : 32'h0;
`ifdef IMEM_ERR_EN
    assign resp_err   = resp_valid & head[32];
`endif

    // Array is not reset; a write coinciding with a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (ld_we && !reset) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pipe_data_q[0] <= stage_in;
        end
        for (int i = 1; i < int'(LATENCY); i++) begin
            pipe_data_q[i] <= pipe_data_q[i-1];
        end
        if (push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= pipe_data_q[LATENCY-1];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            pipe_valid_q[0] <= accept;
            for (int i = 1; i < int'(LATENCY); i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: hand-computed vector table, directed corner sequences and a
// randomized run against a queue-based timing model.
module tb_imem_responder;

    localparam int unsigned DEPTH_WORDS = 256;
    localparam int unsigned LATENCY     = 2;
    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned ADDR_W      = 8;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic              resp_err;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_data;
    logic              busy;

    imem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .LATENCY     (LATENCY),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
`ifdef IMEM_ERR_EN
        .resp_err   (resp_err),
`endif
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .busy       (busy)
    );

`ifndef IMEM_ERR_EN
    assign resp_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: image copy plus queue of expected responses with their due cycle.
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          avail;
    } exp_t;

    logic [31:0] mem_m [DEPTH_WORDS];
    exp_t        q [$];
    int          cyc;
    int          vecs;
    int          miscompares;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] la;
        logic [31:0]       ld;
        logic              rv;
        logic [31:0]       ra;
        logic              rr;
        logic              x_ready;
        logic              x_valid;
        logic [31:0]       x_data;
        logic              x_err;
        logic              x_busy;
    } vec_t;

    vec_t        tbl [15];
    logic [31:0] got [$];
    int          accepts;
    int          first_c;
    int          last_c;
    logic [31:0] held;
    bit          have_held;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic exp_t make_entry(input logic [31:0] ra);
        exp_t e;
        e.avail = 0;
`ifdef IMEM_ERR_EN
        if (ra[1:0] != 2'b00 || (ra >> (ADDR_W + 2)) != 0) begin
            e.data = NOP;
            e.err  = 1'b1;
            return e;
        end
`endif
        e.data = mem_m[ra[ADDR_W+1:2]];
        e.err  = 1'b0;
        return e;
    endfunction

    function automatic bit model_valid();
        return q.size() > 0 && q[0].avail <= cyc;
    endfunction

    function automatic void compare_model();
        check("req_ready", req_ready, q.size() < FIFO_DEPTH);
        check("resp_valid", resp_valid, model_valid());
        if (model_valid()) begin
            check("resp_data", resp_data, q[0].data);
            check("resp_err", resp_err, q[0].err);
        end
        check("busy", busy, q.size() != 0);
    endfunction

    task automatic step(input logic we, input logic [ADDR_W-1:0] la, input logic [31:0] ld,
                        input logic rv, input logic [31:0] ra, input logic rr);
        bit   acc;
        bit   pp;
        exp_t e;
        ld_we      = we;
        ld_addr    = la;
        ld_data    = ld;
        req_valid  = rv;
        req_addr   = ra;
        resp_ready = rr;
        acc = rv && (q.size() < FIFO_DEPTH);
        pp  = rr && model_valid();
        e   = make_entry(ra);
        @(posedge clk);
        cyc++;
        if (pp) void'(q.pop_front());
        if (acc) begin
            e.avail = cyc + LATENCY;
            q.push_back(e);
        end
        if (we) mem_m[la] = ld;
        #1;
        compare_model();
    endtask

    // A loader write is held active across the reset edges; it must be dropped.
    task automatic apply_reset();
        ld_we     = 1'b1;
        ld_addr   = 8'd5;
        ld_data   = 32'hBAD0_BAD0;
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        q.delete();
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ld_we = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        vecs = 0;
        miscompares = 0;
        cyc = 0;
        reset = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        resp_ready = 1'b0;
        ld_we = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
            step(1'b1, ADDR_W'(i), $urandom, 1'b0, 32'h0, 1'b0);
        end
        step(1'b1, 8'd0, 32'h0050_0093, 1'b0, 32'h0, 1'b0);
        apply_reset();

`ifdef IMEM_ERR_EN
        tbl[12] = '{1'b0, 8'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, NOP, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 8'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, NOP, 1'b1, 1'b1};
`else
        tbl[12] = '{1'b0, 8'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0050_0093, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 8'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0050_0093, 1'b0, 1'b1};
`endif
        tbl[0]  = '{1'b0, 8'd0, 32'h0, 1'b1, 32'd0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 8'd0, 32'h0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 8'd0, 32'h0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h0050_0093, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 8'd0, 32'h0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 8'd3, 32'h3333_3333, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 8'd3, 32'hDEAD_BEEF, 1'b1, 32'd12, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 8'd0, 32'h0, 1'b1, 32'd12, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 8'd0, 32'h0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h3333_3333, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 8'd0, 32'h0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 8'd0, 32'h0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 8'd0, 32'h0, 1'b1, 32'd1024, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 8'd0, 32'h0, 1'b1, 32'd2, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 8'd0, 32'h0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};

        foreach (tbl[i]) begin
            step(tbl[i].we, tbl[i].la, tbl[i].ld, tbl[i].rv, tbl[i].ra, tbl[i].rr);
            check($sformatf("tbl%0d_ready", i), req_ready, tbl[i].x_ready);
            check($sformatf("tbl%0d_valid", i), resp_valid, tbl[i].x_valid);
            if (tbl[i].x_valid) begin
                check($sformatf("tbl%0d_data", i), resp_data, tbl[i].x_data);
                check($sformatf("tbl%0d_err", i), resp_err, tbl[i].x_err);
            end
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].x_busy);
        end

        // Word 5 was written only on reset edges, so it must still hold its pre-reset value.
        step(1'b0, 8'd0, 32'h0, 1'b1, 32'd20, 1'b1);
        repeat (LATENCY) step(1'b0, 8'd0, 32'h0, 1'b0, 32'd0, 1'b1);
        check("reset_ld_dropped", resp_data == 32'hBAD0_BAD0, 0);
        step(1'b0, 8'd0, 32'h0, 1'b0, 32'd0, 1'b1);

        // Streaming: back-to-back fetches with resp_ready held high.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, ADDR_W'(i), 32'h1000 + i, 1'b0, 32'h0, 1'b1);
        end
        got.delete();
        first_c = -1;
        last_c = -1;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) check("stream_ready", req_ready, 1);
            step(1'b0, 8'd0, 32'h0, i < 8, 32'(i * 4), 1'b1);
            if (resp_valid) begin
                got.push_back(resp_data);
                if (first_c < 0) first_c = i;
                last_c = i;
            end
        end
        check("stream_count", got.size(), 8);
        check("stream_contiguous", last_c - first_c, 7);
        foreach (got[i]) check($sformatf("stream_word%0d", i), got[i], 32'h1000 + i);

        // Backpressure: requests keep coming while the fetch side stalls.
        accepts = 0;
        have_held = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (req_ready) accepts++;
            step(1'b0, 8'd0, 32'h0, 1'b1, 32'(k * 4), 1'b0);
            if (resp_valid) begin
                if (have_held) check("bp_data_stable", resp_data, held);
                held = resp_data;
                have_held = 1'b1;
            end
        end
        check("bp_accepts", accepts, FIFO_DEPTH);
        check("bp_ready_low", req_ready, 0);
        got.delete();
        for (int k = 0; k < 8; k++) begin
            if (resp_valid) got.push_back(resp_data);
            step(1'b0, 8'd0, 32'h0, 1'b0, 32'h0, 1'b1);
        end
        check("bp_count", got.size(), FIFO_DEPTH);
        foreach (got[i]) check($sformatf("bp_word%0d", i), got[i], 32'h1000 + i);

        // Reset with three fetches in flight discards them all.
        for (int k = 0; k < 3; k++) step(1'b0, 8'd0, 32'h0, 1'b1, 32'(k * 4), 1'b0);
        apply_reset();
        accepts = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 8'd0, 32'h0, 1'b0, 32'h0, 1'b1);
            if (resp_valid) accepts++;
        end
        check("rst_midop_no_resp", accepts, 0);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ra;
            ra = ($urandom % 8 == 0) ? $urandom : $urandom_range(0, DEPTH_WORDS - 1) * 4;
            step(($urandom % 4) == 0, ADDR_W'($urandom), $urandom, ($urandom % 4) != 0, ra,
                 ($urandom % 3) != 0);
        end
        repeat (FIFO_DEPTH + LATENCY + 2) step(1'b0, 8'd0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("drain_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
